// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
//
// Ports:
//   sys_clk, sys_rst                    clock (rising edge), async active-high reset
//   fetch_valid                         IF stage presents an instruction
//   id_rs1, id_rs2, id_uses_rs1/2       ID source operands and their use flags
//   ex_is_load, ex_is_write_rf, ex_rd   EX instruction class and destination
//   ex_redirect                         EX resolved a taken branch/jump
//   mem_req, mem_ready                  MEM data-memory access handshake
//   pc_en, *_en                         PC and pipeline register load enables
//   ifid_flush, idex_flush              load a bubble instead of the upstream stage
//   id/ex/mem/wb_valid                  stage holds a real instruction
//   stall_cycles, flush_count           saturating performance counters
//   mem_timeout                         sticky memory watchdog error
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             fetch_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic             ex_is_write_rf,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [WAIT_W:0]   wait_inc;
  logic              mw, rd, lu, hit_rs1, hit_rs2;
  logic              take_rd, timeout_set;

  // Hazard terms; every term is qualified by the valid bit of the stage it reads.
  always_comb begin
    hit_rs1 = id_uses_rs1 && (id_rs1 == ex_rd);
    hit_rs2 = id_uses_rs2 && (id_rs2 == ex_rd);
    mw      = mem_valid && mem_req && !mem_ready;
    rd      = ex_valid && ex_redirect;
    lu      = ex_valid && ex_is_load && ex_is_write_rf && (ex_rd != 5'd0) &&
              id_valid && (hit_rs1 || hit_rs2);
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    take_rd      = 1'b0;
    timeout_set  = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    // The first waiting cycle loads 1; later ones count up from the held value.
    wait_inc     = (state == RUN) ? (WAIT_W+1)'(1) : ({1'b0, wait_cnt} + (WAIT_W+1)'(1));

    if (state == ERROR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mw) begin
      // Everything upstream of MEM freezes, so a pending redirect or load-use
      // stays in place and is acted on once the access completes.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      wait_cnt_nxt = wait_inc[WAIT_W-1:0];
      if (wait_inc >= (WAIT_W+1)'(MEM_TIMEOUT)) begin
        state_nxt   = ERROR;
        timeout_set = 1'b1;
      end else begin
        state_nxt = MEM_WAIT;
      end
    end else begin
      state_nxt    = RUN;
      wait_cnt_nxt = '0;
      if (rd) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        take_rd    = 1'b1;
      end else if (lu) begin
        // Hold IF/ID, inject one bubble into EX.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      id_valid     <= 1'b0;
      ex_valid     <= 1'b0;
      mem_valid    <= 1'b0;
      wb_valid     <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set) mem_timeout <= 1'b1;
      if (ifid_en)  id_valid  <= fetch_valid && !ifid_flush;
      if (idex_en)  ex_valid  <= id_valid && !idex_flush;
      if (exmem_en) mem_valid <= ex_valid;
      if (memwb_en) wb_valid  <= mem_valid && !mw;
      if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (take_rd && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 8;

  typedef struct {
    logic       fv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ld;
    logic       wr;
    logic [4:0] rd;
    logic       redir;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct {
    string      tag;
    logic [4:0] en;
    logic [1:0] fl;
    logic [3:0] v;
    int         stall;
    int         flush;
    logic       to;
  } exp_t;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             fetch_valid = 1'b0;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic             ex_is_load = 1'b0, ex_is_write_rf = 1'b0, ex_redirect = 1'b0;
  logic             mem_req = 1'b0, mem_ready = 1'b1;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush;
  logic             id_valid, ex_valid, mem_valid, wb_valid;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic             mem_timeout;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 sys_clk = ~sys_clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .fetch_valid(fetch_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_is_write_rf(ex_is_write_rf), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic stim_t base(input logic fv);
    stim_t s;
    s.fv = fv; s.rs1 = '0; s.rs2 = '0; s.u1 = 1'b0; s.u2 = 1'b0;
    s.ld = 1'b0; s.wr = 1'b0; s.rd = '0; s.redir = 1'b0;
    s.mreq = 1'b0; s.mrdy = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    fetch_valid = s.fv; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_is_load = s.ld;
    ex_is_write_rf = s.wr; ex_rd = s.rd; ex_redirect = s.redir;
    mem_req = s.mreq; mem_ready = s.mrdy;
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, ".en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(e.en));
    check({e.tag, ".fl"}, 32'({ifid_flush, idex_flush}), 32'(e.fl));
    check({e.tag, ".v"}, 32'({id_valid, ex_valid, mem_valid, wb_valid}), 32'(e.v));
    check({e.tag, ".stall"}, 32'(stall_cycles), 32'(e.stall));
    check({e.tag, ".flush"}, 32'(flush_count), 32'(e.flush));
    check({e.tag, ".to"}, 32'(mem_timeout), 32'(e.to));
  endtask

  // Drive one cycle of stimulus at the falling edge, record what the DUT must
  // show for it, then sample a little later, well before the rising edge.
  task automatic step(input logic rst, input stim_t s, input string tag,
                      input logic [4:0] en, input logic [1:0] fl, input logic [3:0] v,
                      input int stall, input int flush, input logic to);
    exp_t e;
    @(negedge sys_clk);
    sys_rst = rst;
    apply(s);
    e.tag = tag; e.en = en; e.fl = fl; e.v = v;
    e.stall = stall; e.flush = flush; e.to = to;
    sb_q.push_back(e);
    #2;
    compare_front();
  endtask

  initial begin
    stim_t s;
    s = base(1'b0);
    step(1'b1, s, "reset", 5'b11111, 2'b00, 4'b0000, 0, 0, 1'b0);

    s = base(1'b1);
    step(1'b0, s, "fill1", 5'b11111, 2'b00, 4'b0000, 0, 0, 1'b0);
    step(1'b0, s, "fill2", 5'b11111, 2'b00, 4'b1000, 0, 0, 1'b0);
    step(1'b0, s, "fill3", 5'b11111, 2'b00, 4'b1100, 0, 0, 1'b0);
    step(1'b0, s, "fill4", 5'b11111, 2'b00, 4'b1110, 0, 0, 1'b0);

    s.ld = 1'b1; s.wr = 1'b1; s.rd = 5'd5; s.u2 = 1'b1; s.rs2 = 5'd5;
    step(1'b0, s, "lu_rs2", 5'b00111, 2'b01, 4'b1111, 0, 0, 1'b0);
    step(1'b0, s, "lu_once", 5'b11111, 2'b00, 4'b1011, 1, 0, 1'b0);
    s.rd = 5'd0; s.rs2 = 5'd0;
    step(1'b0, s, "lu_x0", 5'b11111, 2'b00, 4'b1101, 1, 0, 1'b0);
    s.rd = 5'd7; s.u2 = 1'b0; s.u1 = 1'b1; s.rs1 = 5'd7;
    step(1'b0, s, "lu_rs1", 5'b00111, 2'b01, 4'b1110, 1, 0, 1'b0);
    s = base(1'b1);
    step(1'b0, s, "post_lu", 5'b11111, 2'b00, 4'b1011, 2, 0, 1'b0);
    s.ld = 1'b1; s.wr = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3;
    step(1'b0, s, "lu_nouse", 5'b11111, 2'b00, 4'b1101, 2, 0, 1'b0);

    s = base(1'b1); s.redir = 1'b1;
    step(1'b0, s, "redir", 5'b11111, 2'b11, 4'b1110, 2, 0, 1'b0);
    step(1'b0, s, "redir_inv", 5'b11111, 2'b00, 4'b0011, 2, 1, 1'b0);
    s = base(1'b1);
    step(1'b0, s, "refill1", 5'b11111, 2'b00, 4'b1001, 2, 1, 1'b0);
    step(1'b0, s, "refill2", 5'b11111, 2'b00, 4'b1100, 2, 1, 1'b0);
    step(1'b0, s, "refill3", 5'b11111, 2'b00, 4'b1110, 2, 1, 1'b0);

    s.mreq = 1'b1; s.mrdy = 1'b0;
    step(1'b0, s, "mw1", 5'b00001, 2'b00, 4'b1111, 2, 1, 1'b0);
    step(1'b0, s, "mw2", 5'b00001, 2'b00, 4'b1110, 3, 1, 1'b0);
    step(1'b0, s, "mw3", 5'b00001, 2'b00, 4'b1110, 4, 1, 1'b0);
    s.mrdy = 1'b1;
    step(1'b0, s, "mw_done", 5'b11111, 2'b00, 4'b1110, 5, 1, 1'b0);

    s.mrdy = 1'b0; s.redir = 1'b1;
    step(1'b0, s, "mw_rd", 5'b00001, 2'b00, 4'b1111, 5, 1, 1'b0);
    s.mrdy = 1'b1;
    step(1'b0, s, "rd_defer", 5'b11111, 2'b11, 4'b1110, 6, 1, 1'b0);
    s = base(1'b1);
    step(1'b0, s, "rd_after", 5'b11111, 2'b00, 4'b0011, 6, 2, 1'b0);
    s.mreq = 1'b1; s.mrdy = 1'b0;
    step(1'b0, s, "mw_inv", 5'b11111, 2'b00, 4'b1001, 6, 2, 1'b0);
    s = base(1'b1); s.redir = 1'b1; s.ld = 1'b1; s.wr = 1'b1;
    s.rd = 5'd5; s.u1 = 1'b1; s.rs1 = 5'd5;
    step(1'b0, s, "rd_lu", 5'b11111, 2'b11, 4'b1100, 6, 2, 1'b0);
    s = base(1'b1);
    step(1'b0, s, "rd_lu_after", 5'b11111, 2'b00, 4'b0010, 6, 3, 1'b0);
    step(1'b0, s, "refill4", 5'b11111, 2'b00, 4'b1001, 6, 3, 1'b0);
    step(1'b0, s, "refill5", 5'b11111, 2'b00, 4'b1100, 6, 3, 1'b0);
    step(1'b0, s, "refill6", 5'b11111, 2'b00, 4'b1110, 6, 3, 1'b0);
    s.mreq = 1'b1;
    step(1'b0, s, "mem_fast", 5'b11111, 2'b00, 4'b1111, 6, 3, 1'b0);

    s.mrdy = 1'b0;
    step(1'b0, s, "to1", 5'b00001, 2'b00, 4'b1111, 6, 3, 1'b0);
    step(1'b0, s, "to2", 5'b00001, 2'b00, 4'b1110, 7, 3, 1'b0);
    step(1'b0, s, "to3", 5'b00001, 2'b00, 4'b1110, 8, 3, 1'b0);
    step(1'b0, s, "to4", 5'b00001, 2'b00, 4'b1110, 9, 3, 1'b0);
    step(1'b0, s, "err1", 5'b00000, 2'b00, 4'b1110, 10, 3, 1'b1);
    s.mrdy = 1'b1; s.redir = 1'b1;
    step(1'b0, s, "err2", 5'b00000, 2'b00, 4'b1110, 11, 3, 1'b1);
    repeat (300) @(posedge sys_clk);
    s = base(1'b0);
    step(1'b0, s, "err_sat", 5'b00000, 2'b00, 4'b1110, 255, 3, 1'b1);

    step(1'b1, s, "rst_err", 5'b11111, 2'b00, 4'b0000, 0, 0, 1'b0);
    s = base(1'b1);
    step(1'b0, s, "post_rst1", 5'b11111, 2'b00, 4'b0000, 0, 0, 1'b0);
    step(1'b0, s, "post_rst2", 5'b11111, 2'b00, 4'b1000, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
